psum_drain: RTL
===============

# psum_drain

Output-side collector placed directly downstream of the bottom PE of a systolic column. It captures the 32-bit partial sums leaving the column and accumulates them over a configurable number of passes into a DEPTH-entry buffer. After the final pass it requantizes each entry to an unsigned 8-bit activation (ReLU, rounding shift, saturation) and streams the results out over a valid/ready handshake.

## Interface
- accumulationPar, 32, partial-sum width (matches PE accumulator width)
- weightPar, 8, output activation width
- DEPTH, 16, output pixels per tile (power of two, ≥2)
- PASS_W, 4, width of the pass-count field
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle tile start; accepted only in IDLE
- cfg_passes  in  PASS_W  passes to accumulate; sampled on accepted start; value 0 is treated as 1
- cfg_shift  in  5  right-shift amount for requantization; sampled on accepted start
- in_valid  in  1  in_psum is valid this cycle; no backpressure toward the column
- in_psum  in  accumulationPar  signed partial sum from the column
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  weightPar  unsigned requantized activation
- busy  out  1  high in ACCUM or DRAIN
- done  out  1  one-cycle pulse after the last output is accepted

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE → ACCUM on start. On this transition the block latches the cfg fields and clears addr and pass. While not in IDLE, start is ignored.
- ACCUM: each cycle with in_valid high updates entry buf[addr].
  - pass==0: buf[addr] = in_psum.
  - Otherwise: buf[addr] = buf[addr] + in_psum, modulo 2^accumulationPar (wraps, no saturation).
  - addr increments on each valid sample. At DEPTH-1 it wraps to 0 and pass increments.
  - in_valid outside ACCUM is ignored and has no effect.
- ACCUM → DRAIN on the valid sample that writes addr DEPTH-1 while pass == passes-1.
- DRAIN: entries 0..DEPTH-1 are presented in order. Requantization of a signed value v:
  - v ≤ 0 → 0 (ReLU).
  - Otherwise r = (v + (cfg_shift>0 ? 1<<(cfg_shift-1) : 0)) >> cfg_shift. Compute with one guard bit so the rounding add cannot overflow.
  - r > 2^weightPar-1 → 2^weightPar-1 (saturate).
- Handshake: a transfer occurs on the cycle out_valid && out_ready.
  - While out_valid && !out_ready, out_data holds stable.
  - out_valid does not drop until the transfer occurs.
- DRAIN → IDLE on the transfer of entry DEPTH-1. done pulses in the cycle after that transfer. busy drops in the same cycle done is high.
- Reset, at any time: state IDLE, addr=0, pass=0, out_valid=0, out_data=0, done=0, busy=0. Buffer contents are not reset and are don't-care. A tile in progress is abandoned.

## Timing
- ACCUM accepts one sample per cycle, indefinitely; the block never stalls the column.
- The buffer read in DRAIN has one cycle of latency, so first out_valid rises 2 cycles after the final ACCUM write edge. The final write is always visible to the read.
- With out_ready held high, DRAIN delivers one output per cycle: DEPTH outputs in DEPTH consecutive cycles. The read-ahead register must keep this full rate under backpressure release.
- Outputs out_valid, out_data, busy and done are all registered.
- The next start is legal in the cycle done is high, since the FSM is already in IDLE.

## Structure
- Shared package psum_drain_pkg holds:
  - the state enum (IDLE/ACCUM/DRAIN);
  - the requantize function (ReLU, round, shift, saturate), parameterized by widths.
- One sub-module, psum_buffer: a DEPTH × accumulationPar single-clock RAM.
  - One synchronous write port and one synchronous read port.
  - No reset on the storage array.
  - Read-during-write to the same address returns old data. The FSM never relies on this case.

## Test plan
- Single pass, cfg_passes=1, cfg_shift=0, in_psum = 0..15 → out_data 0..15 in order, then done pulse. First out_valid 2 cycles after the last sample.
- Three passes, cfg_passes=3, cfg_shift=2, every sample 5 → each sum 15, (15+2)>>2 = 4 → sixteen outputs of 4.
- ReLU and saturation, cfg_shift=0, passes=1:
  - in_psum -7 → 0.
  - in_psum 300 → 255.
  - in_psum 0x7FFFFFFF → 255.
- Rounding, cfg_shift=3:
  - v=12 → 2, since (12+4)>>3 = 2.
  - v=11 → 1.
  - v=4 → 1.
  - v=3 → 0.
- Backpressure: toggle out_ready randomly during DRAIN → out_data stable while stalled, no loss or duplication, exactly 16 transfers.
- Reset and start/config handling:
  - Assert rst mid-ACCUM and mid-DRAIN → out_valid, busy, done low immediately; a new tile afterwards produces correct results.
  - start during ACCUM is ignored.
  - cfg_passes=0 behaves as 1.

Source files
------------

// File: rtl/psum_drain_pkg.sv
// rtl/psum_drain_pkg.sv - shared widths, FSM state type and requantization helper for psum_drain
package psum_drain_pkg;

    localparam int PSUM_W  = 32;
    localparam int ACT_W   = 8;
    localparam int SHIFT_W = 5;
    localparam int ACT_MAX = (1 << ACT_W) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // ReLU, round-half-up right shift, saturate to ACT_W bits; one guard bit absorbs the rounding carry
    function automatic logic [ACT_W-1:0] requantize(
        input logic signed [PSUM_W-1:0]  v,
        input logic        [SHIFT_W-1:0] shift
    );
        logic [PSUM_W:0]    ext;
        logic [PSUM_W:0]    rnd;
        logic [PSUM_W:0]    r;
        logic [ACT_W-1:0]   res;
        ext = {1'b0, v};
        rnd = '0;
        if (shift != '0) begin
            rnd = (PSUM_W+1)'(1) << (shift - SHIFT_W'(1));
        end
        r = (ext + rnd) >> shift;
        if (v <= 0) begin
            res = '0;
        end else if (r > (PSUM_W+1)'(ACT_MAX)) begin
            res = '1;
        end else begin
            res = r[ACT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/psum_buffer.sv
// rtl/psum_buffer.sv - DEPTH x WIDTH single-clock RAM, one sync write port, one sync read port
module psum_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read-during-write to the same address returns the old contents
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - multi-pass partial-sum accumulator with requantized valid/ready drain
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int accumulationPar = PSUM_W,
    parameter int weightPar       = ACT_W,
    parameter int DEPTH           = 16,
    parameter int PASS_W          = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [PASS_W-1:0]          cfg_passes,
    input  logic [SHIFT_W-1:0]         cfg_shift,
    input  logic                       in_valid,
    input  logic [accumulationPar-1:0] in_psum,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [weightPar-1:0]       out_data,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] RD_END    = CW'(DEPTH);

    state_t                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [PASS_W-1:0]      pass_q, pass_d;
    logic [PASS_W-1:0]      passes_q, passes_d;
    logic [SHIFT_W-1:0]     shift_q, shift_d;
    logic [CW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          xfer_cnt_q, xfer_cnt_d;
    logic                   s1_valid_q, s1_valid_d;
    logic                   out_valid_q, out_valid_d;
    logic [weightPar-1:0]   out_data_q, out_data_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic                       buf_we;
    logic [AW-1:0]              buf_waddr;
    logic [accumulationPar-1:0] buf_wdata;
    logic                       buf_re;
    logic [AW-1:0]              buf_raddr;
    logic [accumulationPar-1:0] buf_rdata;

    logic load_out;
    logic xfer;

    psum_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (accumulationPar),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (buf_wdata),
        .re_i    (buf_re),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    // s1 is the RAM output stage; it refills whenever it is empty or moving into the output register
    assign load_out = s1_valid_q && (!out_valid_q || out_ready);
    assign xfer     = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pass_d      = pass_q;
        passes_d    = passes_q;
        shift_d     = shift_q;
        rd_ptr_d    = rd_ptr_q;
        xfer_cnt_d  = xfer_cnt_q;
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        buf_we      = 1'b0;
        buf_waddr   = addr_q;
        buf_wdata   = in_psum;
        buf_re      = 1'b0;
        buf_raddr   = addr_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ACCUM;
                    addr_d   = '0;
                    pass_d   = '0;
                    passes_d = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
                    shift_d  = cfg_shift;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    buf_we = 1'b1;
                    if (pass_q != '0) begin
                        buf_wdata = buf_rdata + in_psum;
                    end
                    addr_d = addr_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        pass_d = pass_q + 1'b1;
                        if (pass_q == passes_q - 1'b1) begin
                            state_d    = DRAIN;
                            rd_ptr_d   = '0;
                            xfer_cnt_d = '0;
                            s1_valid_d = 1'b0;
                        end
                    end
                end
                // Read ahead at the next write address so the old sum is ready when its sample arrives
                buf_re    = 1'b1;
                buf_raddr = addr_d;
            end
            DRAIN: begin
                if (load_out) begin
                    out_data_d  = requantize(buf_rdata, shift_q);
                    out_valid_d = 1'b1;
                end else if (xfer) begin
                    out_valid_d = 1'b0;
                end
                if ((rd_ptr_q != RD_END) && (!s1_valid_q || load_out)) begin
                    buf_re     = 1'b1;
                    buf_raddr  = rd_ptr_q[AW-1:0];
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    s1_valid_d = 1'b1;
                end else if (load_out) begin
                    s1_valid_d = 1'b0;
                end
                if (xfer) begin
                    xfer_cnt_d = xfer_cnt_q + 1'b1;
                    if (xfer_cnt_q == LAST_ADDR) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            pass_q      <= '0;
            passes_q    <= '0;
            shift_q     <= '0;
            rd_ptr_q    <= '0;
            xfer_cnt_q  <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pass_q      <= pass_d;
            passes_q    <= passes_d;
            shift_q     <= shift_d;
            rd_ptr_q    <= rd_ptr_d;
            xfer_cnt_q  <= xfer_cnt_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
